sdio_cmd_tx: RTL and testbench

//  Serialises one SD-bus command frame onto the CMD line. Sits directly

---
 rtl/sdio_cmd_tx.sv | 154 +++++++++++++++
 tb/tb_sdio_cmd_tx.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdio_cmd_tx.sv
// SD-bus CMD line transmitter: serialises start/dir/cmd/arg/CRC7/end
// and holds the line idle for a post-command gap before accepting more.
module sdio_cmd_tx #(
  parameter int POST_IDLE_CLKS = 8
) (
  input  logic        sdio_clk,
  input  logic        rst_n,
  input  logic        i_tx_en,
  input  logic [5:0]  i_tx_cmd,
  input  logic [31:0] i_tx_para,
  output logic        o_tx_busy,
  output logic        o_tx_done,
  output logic        o_cmd_oe,
  output logic        o_cmd_out
);

  localparam int GW =
    (POST_IDLE_CLKS > 0) ? $clog2(POST_IDLE_CLKS + 1) : 1;
  localparam logic [GW-1:0] GAP_LAST =
    (POST_IDLE_CLKS > 0) ? GW'(POST_IDLE_CLKS - 1) : '0;
  localparam logic [GW-1:0] GAP_ONE = GW'(1);
  localparam logic [5:0] LAST_ARG = 6'd39;
  localparam logic [5:0] LAST_CRC = 6'd46;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_CRC,
    S_STOP,
    S_GAP
  } state_t;

  state_t state_q;
  state_t state_d;

  logic          en_d;
  logic          start;
  logic [39:0]   sh_q;
  logic [6:0]    crc_q;
  logic [6:0]    crc_nxt;
  logic          fb;
  logic [5:0]    bit_cnt;
  logic [GW-1:0] gap_cnt;
  logic          done_q;
  logic          to_idle;

  assign start = i_tx_en & ~en_d & (state_q == S_IDLE);

  // Serial CRC7 (x^7 + x^3 + 1) fed by the bit leaving the shifter
  assign fb      = sh_q[39] ^ crc_q[6];
  assign crc_nxt = {crc_q[5:3], crc_q[2] ^ fb, crc_q[1:0], fb};

  assign to_idle = (state_q != S_IDLE) && (state_d == S_IDLE);

  always_ff @(posedge sdio_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_SEND;
      end
      S_SEND: begin
        if (bit_cnt == LAST_ARG) state_d = S_CRC;
      end
      S_CRC: begin
        if (bit_cnt == LAST_CRC) state_d = S_STOP;
      end
      S_STOP: begin
        state_d = (POST_IDLE_CLKS > 0) ? S_GAP : S_IDLE;
      end
      S_GAP: begin
        if (gap_cnt == GAP_LAST) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sdio_clk or negedge rst_n) begin
    if (!rst_n) begin
      en_d    <= 1'b0;
      sh_q    <= '0;
      crc_q   <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      done_q  <= 1'b0;
    end else begin
      en_d   <= i_tx_en;
      done_q <= to_idle;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            sh_q    <= {1'b0, 1'b1, i_tx_cmd, i_tx_para};
            crc_q   <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
          end
        end
        S_SEND: begin
          sh_q    <= {sh_q[38:0], 1'b0};
          crc_q   <= crc_nxt;
          bit_cnt <= bit_cnt + 6'd1;
        end
        S_CRC: begin
          crc_q   <= {crc_q[5:0], 1'b0};
          bit_cnt <= bit_cnt + 6'd1;
        end
        S_STOP: begin
          bit_cnt <= '0;
          gap_cnt <= '0;
        end
        S_GAP: begin
          if (gap_cnt != GAP_LAST) gap_cnt <= gap_cnt + GAP_ONE;
        end
        default: begin
          bit_cnt <= '0;
          gap_cnt <= '0;
        end
      endcase
    end
  end

  always_comb begin
    o_tx_busy = (state_q != S_IDLE);
    o_tx_done = done_q;
    o_cmd_oe  = 1'b0;
    o_cmd_out = 1'b1;
    unique case (state_q)
      S_SEND: begin
        o_cmd_oe  = 1'b1;
        o_cmd_out = sh_q[39];
      end
      S_CRC: begin
        o_cmd_oe  = 1'b1;
        o_cmd_out = crc_q[6];
      end
      S_STOP: begin
        o_cmd_oe  = 1'b1;
        o_cmd_out = 1'b1;
      end
      default: begin
        o_cmd_oe  = 1'b0;
        o_cmd_out = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_sdio_cmd_tx.sv
// Bench for sdio_cmd_tx: random frames against a polynomial-division
// CRC7 model, plus edge, latch, reset-abort and zero-gap scenarios.
module tb_sdio_cmd_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        en_v;
  logic        sel;
  logic [5:0]  cmd;
  logic [31:0] para;
  logic        en1, en2;
  logic        busy1, done1, oe1, out1;
  logic        busy2, done2, oe2, out2;
  logic        s_busy, s_done, s_oe, s_out;

  assign en1    = sel ? 1'b0 : en_v;
  assign en2    = sel ? en_v : 1'b0;
  assign s_busy = sel ? busy2 : busy1;
  assign s_done = sel ? done2 : done1;
  assign s_oe   = sel ? oe2 : oe1;
  assign s_out  = sel ? out2 : out1;

  sdio_cmd_tx #(.POST_IDLE_CLKS(8)) dut (
    .sdio_clk(clk), .rst_n(rst_n), .i_tx_en(en1),
    .i_tx_cmd(cmd), .i_tx_para(para),
    .o_tx_busy(busy1), .o_tx_done(done1),
    .o_cmd_oe(oe1), .o_cmd_out(out1)
  );

  sdio_cmd_tx #(.POST_IDLE_CLKS(0)) dut0 (
    .sdio_clk(clk), .rst_n(rst_n), .i_tx_en(en2),
    .i_tx_cmd(cmd), .i_tx_para(para),
    .o_tx_busy(busy2), .o_tx_done(done2),
    .o_cmd_oe(oe2), .o_cmd_out(out2)
  );

  int checks = 0;
  int errors = 0;

  logic [47:0] fr;
  int oe_n, oe_first, busy_n, done_at, done_busy, idle_bad;
  logic [47:0] exp_t, got_t;

  // Frame = message bits, remainder of msg*x^7 mod (x^7+x^3+1), end bit
  function automatic logic [47:0] model(input logic [5:0] c,
                                        input logic [31:0] p);
    logic [39:0] msg;
    logic [46:0] v;
    msg = {2'b01, c, p};
    v   = {msg, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (v[i]) v = v ^ (47'h89 << (i - 7));
    return {msg, v[6:0], 1'b1};
  endfunction

  function automatic int post();
    return sel ? 0 : 8;
  endfunction

  function automatic logic [47:0] exp_timing();
    return {8'd48, 8'd1, 8'(48 + post()), 8'(49 + post()), 8'd0, 8'd0};
  endfunction

  task automatic launch(input logic [5:0] c, input logic [31:0] p);
    cmd  = c;
    para = p;
    en_v = 1'b1;
    @(posedge clk);
  endtask

  // mode: 0 plain, 1 en pulse at T+20, 2 change inputs at T+5, 3 hold en
  task automatic capture(input int mode, input int maxc);
    fr = '0; oe_n = 0; oe_first = -1; busy_n = 0;
    done_at = -1; done_busy = 0; idle_bad = 0;
    for (int c = 1; c <= maxc; c++) begin
      @(negedge clk);
      if (s_oe) begin
        fr = {fr[46:0], s_out};
        oe_n++;
        if (oe_first < 0) oe_first = c;
      end else if (s_out !== 1'b1) idle_bad++;
      if (s_busy) busy_n++;
      if (c == 1 && mode != 3) en_v = 1'b0;
      if (mode == 1 && c == 20) en_v = 1'b1;
      if (mode == 1 && c == 21) en_v = 1'b0;
      if (mode == 2 && c == 5) begin
        cmd  = 6'($urandom);
        para = $urandom;
      end
      if (s_done === 1'b1) begin
        done_at   = c;
        done_busy = int'(s_busy);
        break;
      end
    end
    got_t = {8'(oe_n), 8'(oe_first), 8'(busy_n),
             8'(done_at), 8'(done_busy), 8'(idle_bad)};
  endtask

  task automatic test_reset();
    logic [7:0] got;
    rst_n = 1'b1; en_v = 1'b0; sel = 1'b0; cmd = '0; para = '0;
    #1 rst_n = 1'b0;
    #1;
    got = {busy1, done1, oe1, out1, busy2, done2, oe2, out2};
    checks++;
    if (got !== 8'b0001_0001) begin
      errors++;
      $display("FAIL reset_state got %b want 00010001", got);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_cmd0();
    launch(6'd0, 32'd0);
    capture(0, 200);
    checks++;
    if (fr !== 48'h40_0000_0000_95) begin
      errors++;
      $display("FAIL cmd0_frame got %h want 400000000095", fr);
    end
    checks++;
    if (model(6'd0, 32'd0) !== 48'h40_0000_0000_95) begin
      errors++;
      $display("FAIL cmd0_model got %h want 400000000095",
               model(6'd0, 32'd0));
    end
    checks++;
    if (got_t !== exp_timing()) begin
      errors++;
      $display("FAIL cmd0_timing got %h want %h", got_t, exp_timing());
    end
    @(negedge clk);
    checks++;
    if ({s_done, s_busy} !== 2'b00) begin
      errors++;
      $display("FAIL done_one_cycle got %b want 00", {s_done, s_busy});
    end
  endtask

  task automatic test_cmd8();
    launch(6'd8, 32'h0000_01AA);
    capture(0, 200);
    checks++;
    if (fr !== 48'h48_0000_01AA_87) begin
      errors++;
      $display("FAIL cmd8_frame got %h want 48000001aa87", fr);
    end
    checks++;
    if (got_t !== exp_timing()) begin
      errors++;
      $display("FAIL cmd8_timing got %h want %h", got_t, exp_timing());
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    launch(6'd55, 32'd0);
    capture(0, 200);
    checks++;
    if (fr !== 48'h77_0000_0000_65) begin
      errors++;
      $display("FAIL cmd55_frame got %h want 770000000065", fr);
    end
    checks++;
    if (got_t !== exp_timing()) begin
      errors++;
      $display("FAIL cmd55_timing got %h want %h", got_t, exp_timing());
    end
    launch(6'd41, 32'h40FF_8000);
    capture(0, 200);
    checks++;
    if (fr !== model(6'd41, 32'h40FF_8000)) begin
      errors++;
      $display("FAIL b2b_frame got %h want %h",
               fr, model(6'd41, 32'h40FF_8000));
    end
    checks++;
    if (got_t !== exp_timing()) begin
      errors++;
      $display("FAIL b2b_timing got %h want %h", got_t, exp_timing());
    end
    @(negedge clk);
  endtask

  task automatic test_hold_en();
    logic [5:0]  c;
    logic [31:0] p;
    int          extra;
    c = 6'($urandom);
    p = $urandom;
    launch(c, p);
    capture(3, 200);
    checks++;
    if (fr !== model(c, p) || got_t !== exp_timing()) begin
      errors++;
      $display("FAIL hold_frame got %h/%h want %h/%h",
               fr, got_t, model(c, p), exp_timing());
    end
    extra = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (s_oe || s_busy) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL hold_refire got %0d busy cycles want 0", extra);
    end
    en_v = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_pulse_ignored();
    logic [5:0]  c;
    logic [31:0] p;
    c = 6'($urandom);
    p = $urandom;
    launch(c, p);
    capture(1, 200);
    checks++;
    if (fr !== model(c, p)) begin
      errors++;
      $display("FAIL pulse_frame got %h want %h", fr, model(c, p));
    end
    checks++;
    if (got_t !== exp_timing()) begin
      errors++;
      $display("FAIL pulse_timing got %h want %h", got_t, exp_timing());
    end
    @(negedge clk);
    checks++;
    if (s_busy !== 1'b0) begin
      errors++;
      $display("FAIL pulse_queued got busy %b want 0", s_busy);
    end
  endtask

  task automatic test_latch();
    logic [5:0]  c;
    logic [31:0] p;
    c = 6'($urandom);
    p = $urandom;
    launch(c, p);
    capture(2, 200);
    checks++;
    if (fr !== model(c, p)) begin
      errors++;
      $display("FAIL latch_frame got %h want %h", fr, model(c, p));
    end
    checks++;
    if (got_t !== exp_timing()) begin
      errors++;
      $display("FAIL latch_timing got %h want %h", got_t, exp_timing());
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [5:0]  c;
    logic [31:0] p;
    for (int n = 0; n < 6; n++) begin
      c = 6'($urandom);
      p = $urandom;
      launch(c, p);
      capture(0, 200);
      checks++;
      if (fr !== model(c, p)) begin
        errors++;
        $display("FAIL rand%0d_frame got %h want %h", n, fr, model(c, p));
      end
      checks++;
      if (got_t !== exp_timing()) begin
        errors++;
        $display("FAIL rand%0d_timing got %h want %h",
                 n, got_t, exp_timing());
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    logic [5:0]  c;
    logic [31:0] p;
    int          stray;
    launch(6'($urandom), $urandom);
    capture(0, 30);
    checks++;
    if (done_at != -1 || oe_n != 30) begin
      errors++;
      $display("FAIL abort_pre got oe %0d done %0d want 30 -1",
               oe_n, done_at);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({oe1, out1, busy1, done1} !== 4'b0100) begin
      errors++;
      $display("FAIL abort_async got %b want 0100",
               {oe1, out1, busy1, done1});
    end
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (done1 || busy1 || oe1) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL abort_stray got %0d active cycles want 0", stray);
    end
    c = 6'($urandom);
    p = $urandom;
    launch(c, p);
    capture(0, 200);
    checks++;
    if (fr !== model(c, p) || got_t !== exp_timing()) begin
      errors++;
      $display("FAIL abort_after got %h/%h want %h/%h",
               fr, got_t, model(c, p), exp_timing());
    end
    @(negedge clk);
  endtask

  task automatic test_post0();
    sel = 1'b1;
    @(negedge clk);
    launch(6'd0, 32'd0);
    capture(0, 200);
    checks++;
    if (fr !== 48'h40_0000_0000_95) begin
      errors++;
      $display("FAIL post0_frame got %h want 400000000095", fr);
    end
    checks++;
    if (got_t !== exp_timing()) begin
      errors++;
      $display("FAIL post0_timing got %h want %h", got_t, exp_timing());
    end
    @(negedge clk);
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_cmd0();
    test_cmd8();
    test_back_to_back();
    test_hold_en();
    test_pulse_ignored();
    test_latch();
    test_random();
    test_reset_abort();
    test_post0();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
